// File: rtl/fas_pkg.sv
// Shared constants, sample type and controller state encoding for the
// FIR-to-FFT ping-pong frame assembler.
package fas_pkg;

    localparam int FRAME_LEN  = 16;   // samples per FFT frame
    localparam int NUM_FRAMES = 64;   // frames per run
    localparam int SAMPLE_W   = 16;   // signed 8.8 sample width
    localparam int IDX_W      = 4;    // log2(FRAME_LEN)
    localparam int CNT_W      = 7;    // wide enough to hold NUM_FRAMES

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Controller states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/fas_pingpong_buf.sv
// Two 16-entry sample banks: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module fas_pingpong_buf
    import fas_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [IDX_W-1:0] wr_idx,
    input  sample_t          wr_data,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx,
    output sample_t          rd_data
);

    sample_t bank_rd [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            sample_t mem [FRAME_LEN];

            // Store the incoming sample when this bank is the write target
            always_ff @(posedge clk) begin
                if (wr_en && (wr_bank == 1'(gi))) begin
                    mem[wr_idx] <= wr_data;
                end
            end

            assign bank_rd[gi] = mem[rd_idx];
        end
    endgenerate

    assign rd_data = bank_rd[rd_bank];

endmodule

// File: rtl/fas_ctrl.sv
// Frame assembler: collects FIR samples into ping-pong banks, hands full
// banks to the FFT engine one at a time, counts completed frames and flags
// overruns when the writer wraps into a bank the FFT has not released.
module fas_ctrl
    import fas_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             fir_valid,
    input  logic [15:0]      fir_d,
    input  logic             fft_busy,
    input  logic             fft_done,
    input  logic [3:0]       rd_addr,
    output logic [15:0]      rd_data,
    output logic             fft_start,
    output logic             fft_bank,
    output logic [6:0]       frame_cnt,
    output logic             ovf,
    output logic             all_done
);

    logic [1:0]       state_q,     state_d;
    logic             wr_bank_q,   wr_bank_d;
    logic [IDX_W-1:0] wr_idx_q,    wr_idx_d;
    logic             rd_ptr_q,    rd_ptr_d;
    logic [1:0]       full_q,      full_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             ovf_q,       ovf_d;
    logic             fft_bank_q,  fft_bank_d;

    logic wr_en;
    logic wrap;
    logic next_bank;
    logic clr;

    // Reset blocks the write so a sample arriving with rst is dropped
    assign wr_en     = fir_valid && !rst && (state_q != ST_DONE);
    assign wrap      = wr_en && (wr_idx_q == IDX_W'(FRAME_LEN - 1));
    assign next_bank = ~wr_bank_q;
    assign clr       = (state_q == ST_WAIT) && fft_done;

    fas_pingpong_buf u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wr_bank_q),
        .wr_idx  (wr_idx_q),
        .wr_data (fir_d),
        .rd_bank (fft_bank_q),
        .rd_idx  (rd_addr),
        .rd_data (rd_data)
    );

    // Write-side bookkeeping, full flags, overrun detection and controller FSM
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        rd_ptr_d    = rd_ptr_q;
        full_d      = full_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;
        fft_bank_d  = fft_bank_q;

        if (wr_en) begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
        end

        // Overrun: the bank we are about to fill is still owned by the FFT,
        // unless the FFT releases exactly that bank on this same edge.
        if (wrap) begin
            wr_bank_d = next_bank;
            if (full_q[next_bank] && !(clr && (rd_ptr_q == next_bank))) begin
                ovf_d = 1'b1;
            end
        end

        // Clear before set so a coincident set on the same bank wins
        if (clr) begin
            full_d[rd_ptr_q] = 1'b0;
        end
        if (wrap) begin
            full_d[wr_bank_q] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_ptr_q] && !fft_busy) begin
                    state_d    = ST_ISSUE;
                    fft_bank_d = rd_ptr_q;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (fft_done) begin
                    rd_ptr_d = ~rd_ptr_q;
                    if (frame_cnt_q != CNT_W'(NUM_FRAMES)) begin
                        frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    end
                    if (frame_cnt_q == CNT_W'(NUM_FRAMES - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
    end

    // State registers with synchronous reset; buffer contents are untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_ptr_q    <= 1'b0;
            full_q      <= 2'b00;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            fft_bank_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            fft_bank_q  <= fft_bank_d;
        end
    end

    assign fft_start = (state_q == ST_ISSUE);
    assign all_done  = (state_q == ST_DONE);
    assign fft_bank  = fft_bank_q;
    assign frame_cnt = frame_cnt_q;
    assign ovf       = ovf_q;

endmodule
